led_sequencer: RTL and testbench

- Programmable driver for one active-low board LED; replaces hard-coded blink/dim logic in top-level experiments.
- Sits between the top-level prescaler (source of the 10 µs `tick` strobe) and the LED pin.
- Accepts mode/duty commands over a valid/ready handshake.
- Applies them glitch-free at PWM period boundaries; supports OFF, SOLID, BLINK and BREATHE.

---
 rtl/led_sequencer_pkg.sv | 18 +
 rtl/pwm_core.sv | 35 +++
 rtl/led_sequencer.sv | 160 ++++++++++++++++
 tb/tb_led_sequencer.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/led_sequencer_pkg.sv
// Shared definitions for the LED sequencer: mode encodings, PWM width and
// default blink/ramp timing (in PWM periods of 256 ticks, ~2.56 ms each).
package led_sequencer_pkg;

  localparam int PWM_W = 8;

  localparam int DEF_BLINK_ON_PERIODS  = 59;   // ~151 ms lit
  localparam int DEF_BLINK_OFF_PERIODS = 332;  // ~850 ms dark, ~1 Hz total
  localparam int DEF_RAMP_PERIODS      = 2;    // periods per brightness step

  typedef enum logic [1:0] {
    LED_MODE_OFF     = 2'd0,
    LED_MODE_SOLID   = 2'd1,
    LED_MODE_BLINK   = 2'd2,
    LED_MODE_BREATHE = 2'd3
  } led_mode_e;

endpackage

// File: rtl/pwm_core.sv
// 8-bit tick-driven PWM with registered active-low output.
// Ports:
//   clk, reset   clock, async active-high reset
//   tick         count enable strobe
//   duty, gate   compare level and enable for the current period
//   wrap         combinational: tick on the last count (255 -> 0)
//   LED_N        registered active-low drive, one clock behind pwm_cnt
module pwm_core
  import led_sequencer_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic [PWM_W-1:0] duty,
  input  logic             gate,
  output logic             wrap,
  output logic             LED_N
);

  logic [PWM_W-1:0] pwm_cnt;

  assign wrap = tick & (pwm_cnt == '1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pwm_cnt <= '0;
      LED_N   <= 1'b1;
    end else begin
      if (tick) pwm_cnt <= pwm_cnt + PWM_W'(1);
      // duty=0 never lights; duty=255 leaves only count 255 dark
      LED_N <= ~(gate & (pwm_cnt < duty));
    end
  end

endmodule

// File: rtl/led_sequencer.sv
// Programmable single-LED driver: OFF / SOLID / BLINK / BREATHE.
// Commands arrive on a valid/ready handshake and are held pending until the
// first PWM wrap after acceptance, so brightness/gating only ever change on a
// period boundary.
// Ports:
//   clk, reset      clock, async active-high reset
//   tick            10 us prescaler strobe
//   cmd_valid/ready command handshake; ready low while a command is pending
//   cmd_mode        0=OFF 1=SOLID 2=BLINK 3=BREATHE
//   cmd_duty        brightness (SOLID/BLINK) or breathe peak
//   mode_o          currently applied mode
//   period_strobe   one-cycle pulse, one clock after each PWM wrap
//   LED_N           active-low LED drive
module led_sequencer
  import led_sequencer_pkg::*;
#(
  parameter int BLINK_ON_PERIODS  = DEF_BLINK_ON_PERIODS,
  parameter int BLINK_OFF_PERIODS = DEF_BLINK_OFF_PERIODS,
  parameter int RAMP_PERIODS      = DEF_RAMP_PERIODS,
  parameter int CNT_W             = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_mode,
  input  logic [PWM_W-1:0] cmd_duty,
  output logic [1:0]       mode_o,
  output logic             period_strobe,
  output logic             LED_N
);

  led_mode_e        mode_q, mode_d, pmode_q, pmode_d;
  logic [PWM_W-1:0] duty_q, duty_d, pduty_q, pduty_d;
  logic [PWM_W-1:0] level_q, level_d;
  logic [CNT_W-1:0] per_cnt_q, per_cnt_d, cnt_inc;
  logic             pend_q, pend_d;
  logic             phase_on_q, phase_on_d;
  logic             dir_up_q, dir_up_d;
  logic             wrap, gate;
  logic [PWM_W-1:0] eff_duty;

  assign cnt_inc   = per_cnt_q + CNT_W'(1);
  assign cmd_ready = ~pend_q;
  assign mode_o    = mode_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q        <= LED_MODE_OFF;
      pmode_q       <= LED_MODE_OFF;
      duty_q        <= '0;
      pduty_q       <= '0;
      level_q       <= '0;
      per_cnt_q     <= '0;
      pend_q        <= 1'b0;
      phase_on_q    <= 1'b1;
      dir_up_q      <= 1'b1;
      period_strobe <= 1'b0;
    end else begin
      mode_q        <= mode_d;
      pmode_q       <= pmode_d;
      duty_q        <= duty_d;
      pduty_q       <= pduty_d;
      level_q       <= level_d;
      per_cnt_q     <= per_cnt_d;
      pend_q        <= pend_d;
      phase_on_q    <= phase_on_d;
      dir_up_q      <= dir_up_d;
      period_strobe <= wrap;
    end
  end

  always_comb begin
    mode_d     = mode_q;
    pmode_d    = pmode_q;
    duty_d     = duty_q;
    pduty_d    = pduty_q;
    level_d    = level_q;
    per_cnt_d  = per_cnt_q;
    pend_d     = pend_q;
    phase_on_d = phase_on_q;
    dir_up_d   = dir_up_q;

    // Accept and apply are mutually exclusive (accept needs pend_q=0), so a
    // command accepted on a wrap cycle waits for the next wrap.
    if (cmd_valid && !pend_q) begin
      pend_d  = 1'b1;
      pmode_d = led_mode_e'(cmd_mode);
      pduty_d = cmd_duty;
    end

    if (wrap) begin
      if (pend_q) begin
        mode_d     = pmode_q;
        duty_d     = pduty_q;
        pend_d     = 1'b0;
        per_cnt_d  = '0;
        phase_on_d = 1'b1;
        level_d    = '0;
        dir_up_d   = 1'b1;
      end else begin
        unique case (mode_q)
          LED_MODE_BLINK: begin
            if (cnt_inc == (phase_on_q ? CNT_W'(BLINK_ON_PERIODS)
                                       : CNT_W'(BLINK_OFF_PERIODS))) begin
              phase_on_d = ~phase_on_q;
              per_cnt_d  = '0;
            end else begin
              per_cnt_d = cnt_inc;
            end
          end
          LED_MODE_BREATHE: begin
            if (cnt_inc == CNT_W'(RAMP_PERIODS)) begin
              per_cnt_d = '0;
              // Triangle between 0 and duty; duty=0 pins level at 0
              if (dir_up_q) begin
                if (level_q < duty_q) begin
                  level_d = level_q + PWM_W'(1);
                  if (level_d == duty_q) dir_up_d = 1'b0;
                end
              end else if (level_q != '0) begin
                level_d = level_q - PWM_W'(1);
                if (level_d == '0) dir_up_d = 1'b1;
              end
            end else begin
              per_cnt_d = cnt_inc;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Derived purely from state that only moves on a wrap, so the compare
  // level cannot change mid-period.
  always_comb begin
    eff_duty = '0;
    gate     = 1'b0;
    unique case (mode_q)
      LED_MODE_OFF:     begin eff_duty = '0;      gate = 1'b0;       end
      LED_MODE_SOLID:   begin eff_duty = duty_q;  gate = 1'b1;       end
      LED_MODE_BLINK:   begin eff_duty = duty_q;  gate = phase_on_q; end
      LED_MODE_BREATHE: begin eff_duty = level_q; gate = 1'b1;       end
      default:          ;
    endcase
  end

  pwm_core u_pwm (
    .clk   (clk),
    .reset (reset),
    .tick  (tick),
    .duty  (eff_duty),
    .gate  (gate),
    .wrap  (wrap),
    .LED_N (LED_N)
  );

endmodule

// File: tb/tb_led_sequencer.sv
module tb_led_sequencer;

  localparam int ON = 2, OFF = 3, RAMP = 1;

  logic       clk = 1'b0, reset = 1'b1, tick = 1'b0, cmd_valid = 1'b0;
  logic [1:0] cmd_mode = 2'd0;
  logic [7:0] cmd_duty = 8'd0;
  logic       cmd_ready, period_strobe, LED_N;
  logic [1:0] mode_o;

  led_sequencer #(.BLINK_ON_PERIODS(ON), .BLINK_OFF_PERIODS(OFF),
                  .RAMP_PERIODS(RAMP), .CNT_W(10)) dut (
    .clk(clk), .reset(reset), .tick(tick), .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready), .cmd_mode(cmd_mode), .cmd_duty(cmd_duty),
    .mode_o(mode_o), .period_strobe(period_strobe), .LED_N(LED_N));

  always #5 clk = ~clk;

  int checks = 0, errors = 0, nprint = 0;
  int tdiv = 0, tmode = 0;
  bit chk_en = 1'b0;

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      if (nprint < 40) $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
      nprint++;
    end
  endtask

  // ---------------- behavioural model ----------------
  // Brightness of period k after a command was applied, straight from the
  // mode definitions: blink is a (ON lit, OFF dark) cycle, breathe is a
  // triangle wave 0..duty..0 stepping once every RAMP periods.
  function automatic int bright(int mode, int duty, int k);
    int s, p;
    case (mode)
      1: return duty;
      2: return ((k % (ON + OFF)) < ON) ? duty : 0;
      3: begin
        if (duty == 0) return 0;
        s = k / RAMP;
        p = s % (2 * duty);
        return (p <= duty) ? p : 2 * duty - p;
      end
      default: return 0;
    endcase
  endfunction

  int   m_cnt, m_k, m_mode, m_duty, p_mode, p_duty;
  bit   m_pend, m_ready, exp_led, exp_strobe;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_cnt <= 0; m_k <= 0; m_mode <= 0; m_duty <= 0; p_mode <= 0; p_duty <= 0;
      m_pend <= 0; m_ready <= 1; exp_led <= 1; exp_strobe <= 0;
    end else begin
      bit w;
      w = tick && (m_cnt == 255);
      exp_led    <= !(m_cnt < bright(m_mode, m_duty, m_k));
      exp_strobe <= w;
      if (w) begin
        if (m_pend) begin
          m_mode <= p_mode; m_duty <= p_duty; m_k <= 0; m_pend <= 0; m_ready <= 1;
        end else m_k <= m_k + 1;
      end
      if (cmd_valid && m_ready) begin
        m_pend <= 1; m_ready <= 0; p_mode <= int'(cmd_mode); p_duty <= int'(cmd_duty);
      end
      if (tick) m_cnt <= (m_cnt + 1) % 256;
    end
  end

  always @(negedge clk) begin
    if (!reset && chk_en) begin
      check("led_n", LED_N, exp_led);
      check("mode_o", mode_o, m_mode);
      check("cmd_ready", cmd_ready, m_ready);
      check("period_strobe", period_strobe, exp_strobe);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clk); #1;
    tdiv = (tdiv + 1) % 4;
    case (tmode)
      0: tick = (tdiv == 0);
      1: tick = 1'b1;
      default: tick = ($urandom_range(0, 3) != 0);
    endcase
  endtask

  function automatic bit wrap_next();
    return tick && (m_cnt == 255);
  endfunction

  task automatic wait_wraps(int n);
    for (int i = 0; i < n; i++) begin
      bit w;
      int b = 0;
      do begin w = wrap_next(); cyc(); b++; end while (!w && b < 3000);
      if (!w) begin errors++; $display("FAIL wrap_timeout: no wrap within %0d cycles", b); end
    end
  endtask

  task automatic measure_period(output int low);
    bit w;
    int b = 0;
    low = 0;
    do begin
      w = wrap_next(); cyc(); b++;
      if (LED_N == 1'b0) low++;
    end while (!w && b < 3000);
    if (!w) begin errors++; $display("FAIL period_timeout: no wrap within %0d cycles", b); end
  endtask

  task automatic send_cmd(int mode, int duty);
    int b = 0;
    while (!cmd_ready && b < 5000) begin cyc(); b++; end
    if (!cmd_ready) begin errors++; $display("FAIL ready_timeout: cmd_ready stuck low"); end
    cmd_valid = 1'b1; cmd_mode = 2'(mode); cmd_duty = 8'(duty);
    cyc();
    cmd_valid = 1'b0;
  endtask

  int blink_exp[6]   = '{1020, 1020, 0, 0, 0, 1020};
  int breathe_lvl[8] = '{0, 1, 2, 3, 2, 1, 0, 1};

  initial begin
    int low, strobes, b;

    // reset
    repeat (3) cyc();
    reset = 1'b0;
    chk_en = 1'b1;
    check("rst_led_n", LED_N, 1);
    check("rst_ready", cmd_ready, 1);
    check("rst_mode", mode_o, 0);
    check("rst_strobe", period_strobe, 0);

    // two idle periods
    strobes = 0; low = 0;
    for (int i = 0; i < 2100; i++) begin
      cyc();
      if (period_strobe) strobes++;
      if (!LED_N) low++;
    end
    check("idle_strobes", strobes, 2);
    check("idle_low", low, 0);

    // SOLID 64
    send_cmd(1, 64);
    check("solid_ready_drop", cmd_ready, 0);
    check("solid_mode_before", mode_o, 0);
    wait_wraps(1);
    check("solid_mode_applied", mode_o, 1);
    check("solid_ready_back", cmd_ready, 1);
    measure_period(low);
    check("solid_low_clocks", low, 64 * 4);

    // accept on the wrap cycle itself
    b = 0;
    while (!wrap_next() && b < 3000) begin cyc(); b++; end
    cmd_valid = 1'b1; cmd_mode = 2'd0; cmd_duty = 8'd0;
    cyc();
    cmd_valid = 1'b1; cmd_mode = 2'd3; cmd_duty = 8'd99;  // ignored: not ready
    check("coinc_ready", cmd_ready, 0);
    check("coinc_mode_kept", mode_o, 1);
    repeat (3) cyc();
    cmd_valid = 1'b0;
    wait_wraps(1);
    check("coinc_mode_next", mode_o, 0);
    measure_period(low);
    check("off_low", low, 0);
    check("ignored_mode", mode_o, 0);

    // BLINK 255
    for (int k = 0; k < 6; k++) check("model_blink", bright(2, 255, k) * 4, blink_exp[k]);
    send_cmd(2, 255);
    wait_wraps(1);
    check("blink_mode", mode_o, 2);
    for (int k = 0; k < 6; k++) begin
      measure_period(low);
      check("blink_period", low, blink_exp[k]);
    end

    // BREATHE 3
    for (int k = 0; k < 8; k++) check("model_breathe", bright(3, 3, k), breathe_lvl[k]);
    send_cmd(3, 3);
    wait_wraps(1);
    for (int k = 0; k < 8; k++) begin
      measure_period(low);
      check("breathe_period", low, breathe_lvl[k] * 4);
    end

    // BREATHE 0
    send_cmd(3, 0);
    wait_wraps(1);
    for (int k = 0; k < 2; k++) begin
      measure_period(low);
      check("breathe0_low", low, 0);
    end

    // reset mid-BLINK with a pending command
    send_cmd(2, 200);
    wait_wraps(2);
    send_cmd(1, 10);
    check("pend_ready", cmd_ready, 0);
    check("pre_rst_led", LED_N, 0);
    #3 reset = 1'b1;
    #1;
    check("async_led_n", LED_N, 1);
    check("async_mode", mode_o, 0);
    check("async_ready", cmd_ready, 1);
    check("async_strobe", period_strobe, 0);
    repeat (3) cyc();
    reset = 1'b0;
    wait_wraps(2);
    check("post_rst_mode", mode_o, 0);
    check("post_rst_ready", cmd_ready, 1);
    measure_period(low);
    check("post_rst_low", low, 0);

    // randomized traffic: random tick density, then tick held high
    for (int seg = 0; seg < 2; seg++) begin
      tmode = (seg == 0) ? 2 : 1;
      for (int i = 0; i < (seg == 0 ? 12000 : 4000); i++) begin
        if (cmd_ready && $urandom_range(0, 99) == 0) begin
          cmd_valid = 1'b1;
          cmd_mode  = 2'($urandom_range(0, 3));
          cmd_duty  = (cmd_mode == 2'd3) ? 8'($urandom_range(0, 6)) : 8'($urandom_range(0, 255));
        end else begin
          cmd_valid = ($urandom_range(0, 49) == 0);
          cmd_mode  = 2'($urandom_range(0, 3));
          cmd_duty  = 8'($urandom_range(0, 255));
        end
        cyc();
      end
      cmd_valid = 1'b0;
    end
    repeat (4) cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
